// File: rtl/scan_mux.sv
// Registered channel multiplexer with manual select and a dwell-timed
// round-robin scan mode.
module scan_mux #(
   parameter int WIDTH = 1,
   parameter int SELW  = 2,
   parameter int DWELL = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [(2**SELW)*WIDTH-1:0]    x,
   input  logic [SELW-1:0]               sel,
   input  logic                          mode,
   input  logic                          en,
   output logic [WIDTH-1:0]              out1,
   output logic [SELW-1:0]               ch,
   output logic                          valid,
   output logic                          wrap
);

   localparam logic [7:0] DLAST = 8'(DWELL - 1);

   logic [SELW-1:0] ptr;
   logic [SELW-1:0] ptr_n;
   logic [SELW-1:0] idx;
   logic [7:0]      dcnt;
   logic [7:0]      dcnt_n;
   logic            lastmode;
   logic            entry;
   logic            adv;

   // ptr_n is the channel shown for this capture; entry is dwell cycle 0.
   always_comb begin
      entry  = mode & ~lastmode;
      adv    = ~entry & (dcnt == DLAST);
      ptr_n  = ptr;
      dcnt_n = dcnt;
      if (entry) begin
         ptr_n  = sel;
         dcnt_n = '0;
      end else if (adv) begin
         ptr_n  = ptr + 1'b1;
         dcnt_n = '0;
      end else begin
         dcnt_n = dcnt + 8'd1;
      end
      idx = mode ? ptr_n : sel;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out1     <= '0;
         ch       <= '0;
         valid    <= 1'b0;
         wrap     <= 1'b0;
         ptr      <= '0;
         dcnt     <= '0;
         lastmode <= 1'b0;
      end else if (en) begin
         out1     <= x[idx*WIDTH +: WIDTH];
         ch       <= idx;
         valid    <= 1'b1;
         wrap     <= mode & adv & (ptr == '1);
         lastmode <= mode;
         if (mode) begin
            ptr  <= ptr_n;
            dcnt <= dcnt_n;
         end
      end else begin
         valid <= 1'b0;
         wrap  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: three configurations driven in parallel and
// compared against a position-arithmetic reference model.
module tb_scan_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] x;
   logic [1:0]  sel;
   logic        mode;
   logic        en;

   logic [3:0]  o1 [3];
   logic [1:0]  cha;
   logic [1:0]  chb;
   logic        chc;
   logic        v [3];
   logic        w [3];

   int ntest = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   scan_mux #(.WIDTH(4), .SELW(2), .DWELL(2)) ua (
      .clk(clk), .rst(rst), .x(x), .sel(sel), .mode(mode), .en(en),
      .out1(o1[0]), .ch(cha), .valid(v[0]), .wrap(w[0]));

   scan_mux #(.WIDTH(4), .SELW(2), .DWELL(1)) ub (
      .clk(clk), .rst(rst), .x(x), .sel(sel), .mode(mode), .en(en),
      .out1(o1[1]), .ch(chb), .valid(v[1]), .wrap(w[1]));

   scan_mux #(.WIDTH(4), .SELW(1), .DWELL(3)) uc (
      .clk(clk), .rst(rst), .x(x[7:0]), .sel(sel[0]), .mode(mode),
      .en(en), .out1(o1[2]), .ch(chc), .valid(v[2]), .wrap(w[2]));

   // model: channel = (start + steps/DWELL) mod NCH since scan entry
   typedef struct {
      int start;
      int s;
      bit lm;
      int o;
      int c;
      bit v;
      bit w;
   } ms_t;

   ms_t m [3];
   int  dw [3] = '{2, 1, 3};
   int  nc [3] = '{4, 4, 2};

   typedef struct {
      bit          en;
      bit          mode;
      logic [1:0]  sel;
      int          ch;
      int          o;
      bit          v;
      bit          w;
   } vec_t;

   vec_t vt [12];

   function automatic int chunk(int c);
      return int'((x >> (4 * c)) & 16'hF);
   endfunction

   task automatic mreset();
      for (int i = 0; i < 3; i++) m[i] = '{default: 0};
   endtask

   task automatic mstep();
      for (int i = 0; i < 3; i++) begin
         int sl;
         sl = int'(sel) % nc[i];
         if (!en) begin
            m[i].v = 0;
            m[i].w = 0;
         end else if (!mode) begin
            m[i].c  = sl;
            m[i].o  = chunk(sl);
            m[i].v  = 1;
            m[i].w  = 0;
            m[i].lm = 0;
         end else if (!m[i].lm) begin
            m[i].start = sl;
            m[i].s     = 0;
            m[i].c     = sl;
            m[i].o     = chunk(sl);
            m[i].v     = 1;
            m[i].w     = 0;
            m[i].lm    = 1;
         end else begin
            m[i].s = m[i].s + 1;
            m[i].c = (m[i].start + m[i].s / dw[i]) % nc[i];
            m[i].o = chunk(m[i].c);
            m[i].v = 1;
            m[i].w = (m[i].s % dw[i] == 0) && (m[i].c == 0);
         end
      end
   endtask

   task automatic chk(string nm, int act, int exp);
      ntest++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic int chof(int i);
      if (i == 0) return int'(cha);
      if (i == 1) return int'(chb);
      return int'(chc);
   endfunction

   task automatic cmp_all(string tag);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s u%0d out1", tag, i), int'(o1[i]), m[i].o);
         chk($sformatf("%s u%0d ch", tag, i), chof(i), m[i].c);
         chk($sformatf("%s u%0d valid", tag, i), int'(v[i]), int'(m[i].v));
         chk($sformatf("%s u%0d wrap", tag, i), int'(w[i]), int'(m[i].w));
      end
   endtask

   task automatic step(string tag);
      @(posedge clk);
      if (rst) mreset();
      else mstep();
      #1;
      cmp_all(tag);
   endtask

   initial begin
      // manual sweep then DWELL=2 scan from channel 2
      vt[0]  = '{1, 0, 2'd0, 0, 10, 1, 0};
      vt[1]  = '{1, 0, 2'd1, 1, 11, 1, 0};
      vt[2]  = '{1, 0, 2'd2, 2, 12, 1, 0};
      vt[3]  = '{1, 0, 2'd3, 3, 13, 1, 0};
      vt[4]  = '{1, 1, 2'd2, 2, 12, 1, 0};
      vt[5]  = '{1, 1, 2'd2, 2, 12, 1, 0};
      vt[6]  = '{1, 1, 2'd2, 3, 13, 1, 0};
      vt[7]  = '{1, 1, 2'd2, 3, 13, 1, 0};
      vt[8]  = '{1, 1, 2'd2, 0, 10, 1, 1};
      vt[9]  = '{1, 1, 2'd2, 0, 10, 1, 0};
      vt[10] = '{1, 1, 2'd2, 1, 11, 1, 0};
      vt[11] = '{1, 1, 2'd2, 1, 11, 1, 0};

      rst  = 1'b1;
      en   = 1'b0;
      mode = 1'b0;
      sel  = 2'd0;
      x    = 16'h0;
      mreset();
      #1;
      cmp_all("reset");
      step("reset_edge");
      rst = 1'b0;

      x = 16'hDCBA;
      for (int k = 0; k < 12; k++) begin
         en   = vt[k].en;
         mode = vt[k].mode;
         sel  = vt[k].sel;
         step($sformatf("vec%0d", k));
         chk($sformatf("vec%0d ch", k), int'(cha), vt[k].ch);
         chk($sformatf("vec%0d out1", k), int'(o1[0]), vt[k].o);
         chk($sformatf("vec%0d valid", k), int'(v[0]), int'(vt[k].v));
         chk($sformatf("vec%0d wrap", k), int'(w[0]), int'(vt[k].w));
      end

      // enable gap at ch=1 with DWELL=1
      mode = 1'b0;
      sel  = 2'd0;
      step("gap_man");
      mode = 1'b1;
      step("gap_entry");
      step("gap_ch1");
      chk("gap pre ch", int'(chb), 1);
      en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step("gap_hold");
         chk("gap hold ch", int'(chb), 1);
         chk("gap hold valid", int'(v[1]), 0);
         chk("gap hold wrap", int'(w[1]), 0);
      end
      en = 1'b1;
      step("gap_resume");
      chk("gap resume ch", int'(chb), 2);
      step("gap_ch3");
      chk("gap ch3", int'(chb), 3);

      // asynchronous reset between edges
      @(negedge clk);
      rst  = 1'b1;
      mode = 1'b1;
      sel  = 2'd1;
      #1;
      mreset();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("arst u%0d out1", i), int'(o1[i]), 0);
         chk($sformatf("arst u%0d ch", i), chof(i), 0);
         chk($sformatf("arst u%0d valid", i), int'(v[i]), 0);
         chk($sformatf("arst u%0d wrap", i), int'(w[i]), 0);
      end
      @(negedge clk);
      rst = 1'b0;
      step("arst_entry");
      chk("arst entry ch", int'(chb), 1);
      chk("arst entry wrap", int'(w[1]), 0);
      step("arst_ch2");
      step("arst_ch3");
      chk("toggle pre ch", int'(chb), 3);

      // scan -> manual -> scan re-entry
      mode = 1'b0;
      sel  = 2'd0;
      step("tog_man0");
      chk("tog man ch a", int'(chb), 0);
      step("tog_man1");
      chk("tog man ch b", int'(chb), 0);
      mode = 1'b1;
      sel  = 2'd2;
      step("tog_entry");
      chk("tog entry ch", int'(chb), 2);
      step("tog_next");
      chk("tog next ch", int'(chb), 3);

      // data tracking on a fixed manual channel
      mode = 1'b0;
      sel  = 2'd1;
      for (int k = 0; k < 6; k++) begin
         logic [3:0] d;
         d = 4'(k * 5 + 3);
         x[7:4] = d;
         step("track");
         chk("track out1", int'(o1[0]), int'(d));
      end

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         en  = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) mode = ~mode;
         sel = 2'($urandom);
         x   = 16'($urandom);
         rst = ($urandom_range(0, 60) == 0);
         step("rand");
      end
      rst = 1'b0;
      step("final");

      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

endmodule
